// File: rtl/pipeline_flow_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline flow controller.
// Stage indices double as the index of the pipeline register feeding that stage.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      CTRL_RUN,
      CTRL_LD_STALL,
      CTRL_MC_BUSY
   } ctrl_state_t;

   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EXE = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;

   // Wide enough for LOAD_LAT-1 with LOAD_LAT up to 4
   localparam int LD_CNT_W = 3;

endpackage

// File: rtl/pipeline_flow_ctrl_load_use_detect.sv
// Combinational load-use hazard detector between the load in EXE and the
// instruction in ID; x0 never creates a dependency.
module load_use_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] rs1_id,
   input  logic [4:0] rs2_id,
   input  logic       use_rs1_id,
   input  logic       use_rs2_id,
   input  logic [4:0] rd_exe,
   input  logic       mem_read_exe,
   output logic       load_use
);

   assign load_use = mem_read_exe && (rd_exe != 5'd0) &&
                     ((use_rs1_id && (rs1_id == rd_exe)) ||
                      (use_rs2_id && (rs2_id == rd_exe)));

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// Pipeline flow controller: load-use bubbles, branch flushes, multicycle-ALU
// hold with timeout, external stall, and a saturating stall-cycle counter.
module pipeline_flow_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned LOAD_LAT   = 1,
   parameter int unsigned BR_STAGE   = 3,
   parameter int unsigned MC_TIMEOUT = 64,
   parameter int unsigned PERF_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        rs1_id,
   input  logic [4:0]        rs2_id,
   input  logic              use_rs1_id,
   input  logic              use_rs2_id,
   input  logic [4:0]        rd_exe,
   input  logic              mem_read_exe,
   input  logic              mc_start_exe,
   input  logic              mc_done,
   input  logic              branch_taken,
   input  logic              stall_pipl,
   output logic              pc_reg_en,
   output logic              if_id_reg_en,
   output logic              id_exe_reg_en,
   output logic              exe_mem_reg_en,
   output logic              mem_wb_reg_en,
   output logic              if_id_reg_clr,
   output logic              id_exe_reg_clr,
   output logic              exe_mem_reg_clr,
   output logic              mem_wb_reg_clr,
   output logic              mc_timeout,
   output logic [PERF_W-1:0] stall_cycles
);

   localparam int MC_CNT_W = $clog2(MC_TIMEOUT);
   localparam logic [MC_CNT_W-1:0] MC_LAST = MC_CNT_W'(MC_TIMEOUT - 1);
   localparam logic [LD_CNT_W-1:0] LD_INIT = LD_CNT_W'(LOAD_LAT - 1);

   ctrl_state_t               state, state_nxt;
   logic [LD_CNT_W-1:0]       ld_cnt, ld_cnt_nxt;
   logic [MC_CNT_W-1:0]       mc_cnt, mc_cnt_nxt;
   logic                      timeout_set;
   logic                      load_use;
   logic [STG_WB:STG_IF+1]    reg_en;
   logic [STG_WB:STG_IF+1]    reg_clr;

   load_use_detect u_load_use_detect (
      .rs1_id       (rs1_id),
      .rs2_id       (rs2_id),
      .use_rs1_id   (use_rs1_id),
      .use_rs2_id   (use_rs2_id),
      .rd_exe       (rd_exe),
      .mem_read_exe (mem_read_exe),
      .load_use     (load_use)
   );

   // Per-cycle priority: reset > external stall > branch flush > MC hold > load-use > run
   always_comb begin
      state_nxt   = state;
      ld_cnt_nxt  = ld_cnt;
      mc_cnt_nxt  = mc_cnt;
      timeout_set = 1'b0;
      pc_reg_en   = 1'b1;
      reg_en      = '1;
      reg_clr     = '0;
      if (reset) begin
         pc_reg_en = 1'b0;
         reg_en    = '0;
         reg_clr   = '1;
      end else if (stall_pipl) begin
         pc_reg_en = 1'b0;
         reg_en    = '0;
      end else if (branch_taken) begin
         reg_clr[STG_ID]  = 1'b1;
         reg_clr[STG_EXE] = 1'b1;
         if (BR_STAGE == STG_MEM) reg_clr[STG_MEM] = 1'b1;
         // The stalled consumer is squashed, so its remaining bubbles are dropped
         if (state == CTRL_LD_STALL) begin
            state_nxt  = CTRL_RUN;
            ld_cnt_nxt = '0;
         end
      end else begin
         case (state)
            CTRL_MC_BUSY: begin
               if (mc_done) begin
                  state_nxt  = CTRL_RUN;
                  mc_cnt_nxt = '0;
               end else begin
                  pc_reg_en        = 1'b0;
                  reg_en[STG_ID]   = 1'b0;
                  reg_en[STG_EXE]  = 1'b0;
                  reg_en[STG_MEM]  = 1'b0;
                  reg_clr[STG_MEM] = 1'b1;
                  if (mc_cnt == MC_LAST) begin
                     timeout_set = 1'b1;
                     state_nxt   = CTRL_RUN;
                     mc_cnt_nxt  = '0;
                  end else begin
                     mc_cnt_nxt = mc_cnt + 1'b1;
                  end
               end
            end
            CTRL_LD_STALL: begin
               pc_reg_en        = 1'b0;
               reg_en[STG_ID]   = 1'b0;
               reg_clr[STG_EXE] = 1'b1;
               if (ld_cnt <= LD_CNT_W'(1)) begin
                  state_nxt  = CTRL_RUN;
                  ld_cnt_nxt = '0;
               end else begin
                  ld_cnt_nxt = ld_cnt - 1'b1;
               end
            end
            default: begin
               if (mc_start_exe) begin
                  state_nxt  = CTRL_MC_BUSY;
                  mc_cnt_nxt = '0;
               end else if (load_use) begin
                  pc_reg_en        = 1'b0;
                  reg_en[STG_ID]   = 1'b0;
                  reg_clr[STG_EXE] = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_nxt  = CTRL_LD_STALL;
                     ld_cnt_nxt = LD_INIT;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= CTRL_RUN;
         ld_cnt <= '0;
         mc_cnt <= '0;
      end else begin
         state  <= state_nxt;
         ld_cnt <= ld_cnt_nxt;
         mc_cnt <= mc_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mc_timeout   <= 1'b0;
         stall_cycles <= '0;
      end else begin
         if (timeout_set) mc_timeout <= 1'b1;
         if (!pc_reg_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      end
   end

   assign if_id_reg_en    = reg_en[STG_ID];
   assign id_exe_reg_en   = reg_en[STG_EXE];
   assign exe_mem_reg_en  = reg_en[STG_MEM];
   assign mem_wb_reg_en   = reg_en[STG_WB];
   assign if_id_reg_clr   = reg_clr[STG_ID];
   assign id_exe_reg_clr  = reg_clr[STG_EXE];
   assign exe_mem_reg_clr = reg_clr[STG_MEM];
   assign mem_wb_reg_clr  = reg_clr[STG_WB];

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Two differently parameterised controllers driven in lockstep, each compared
// every cycle against a behavioural model of bubbles-remaining / busy-age.
module tb_pipeline_flow_ctrl;

   // Control vector order: {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, if_id_clr, id_exe_clr, exe_mem_clr, mem_wb_clr}
   localparam logic [8:0] V_DEF  = 9'b1_1111_0000;
   localparam logic [8:0] V_RST  = 9'b0_0000_1111;
   localparam logic [8:0] V_STL  = 9'b0_0000_0000;
   localparam logic [8:0] V_HAZ  = 9'b0_0111_0100;
   localparam logic [8:0] V_BUSY = 9'b0_0001_0010;
   localparam logic [8:0] V_BR3  = 9'b1_1111_1110;
   localparam logic [8:0] V_BR2  = 9'b1_1111_1100;

   logic       clk = 1'b0;
   logic       reset, use_rs1_id, use_rs2_id, mem_read_exe;
   logic       mc_start_exe, mc_done, branch_taken, stall_pipl;
   logic [4:0] rs1_id, rs2_id, rd_exe;
   logic [8:0] ctl_a, ctl_b;
   logic       to_a, to_b;
   logic [7:0] sc_a, sc_b;

   int lat [2] = '{3, 1};
   int brs [2] = '{3, 2};
   int tmo [2] = '{12, 8};
   int load_left [2];
   int mc_active [2];
   int mc_age [2];
   int to_m [2];
   int stalls_m [2];
   int compared = 0;
   int mismatched = 0;
   bit primed = 1'b0;

   always #5 clk = ~clk;

   pipeline_flow_ctrl #(.LOAD_LAT(3), .BR_STAGE(3), .MC_TIMEOUT(12), .PERF_W(8)) dut_a (
      .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_exe(rd_exe),
      .mem_read_exe(mem_read_exe), .mc_start_exe(mc_start_exe), .mc_done(mc_done),
      .branch_taken(branch_taken), .stall_pipl(stall_pipl),
      .pc_reg_en(ctl_a[8]), .if_id_reg_en(ctl_a[7]), .id_exe_reg_en(ctl_a[6]),
      .exe_mem_reg_en(ctl_a[5]), .mem_wb_reg_en(ctl_a[4]), .if_id_reg_clr(ctl_a[3]),
      .id_exe_reg_clr(ctl_a[2]), .exe_mem_reg_clr(ctl_a[1]), .mem_wb_reg_clr(ctl_a[0]),
      .mc_timeout(to_a), .stall_cycles(sc_a)
   );

   pipeline_flow_ctrl #(.LOAD_LAT(1), .BR_STAGE(2), .MC_TIMEOUT(8), .PERF_W(8)) dut_b (
      .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_exe(rd_exe),
      .mem_read_exe(mem_read_exe), .mc_start_exe(mc_start_exe), .mc_done(mc_done),
      .branch_taken(branch_taken), .stall_pipl(stall_pipl),
      .pc_reg_en(ctl_b[8]), .if_id_reg_en(ctl_b[7]), .id_exe_reg_en(ctl_b[6]),
      .exe_mem_reg_en(ctl_b[5]), .mem_wb_reg_en(ctl_b[4]), .if_id_reg_clr(ctl_b[3]),
      .id_exe_reg_clr(ctl_b[2]), .exe_mem_reg_clr(ctl_b[1]), .mem_wb_reg_clr(ctl_b[0]),
      .mc_timeout(to_b), .stall_cycles(sc_b)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural model: expected controls for this cycle, then state advance
   task automatic modelCycle(input int k, output logic [8:0] e);
      bit hz;
      hz = mem_read_exe && (rd_exe != 5'd0) &&
           ((use_rs1_id && (rs1_id == rd_exe)) || (use_rs2_id && (rs2_id == rd_exe)));
      e = V_DEF;
      if (reset) begin
         e = V_RST;
         load_left[k] = 0; mc_active[k] = 0; mc_age[k] = 0; to_m[k] = 0; stalls_m[k] = 0;
         return;
      end
      if (stall_pipl) begin
         e = V_STL;
      end else if (branch_taken) begin
         e = (brs[k] == 3) ? V_BR3 : V_BR2;
         load_left[k] = 0;
      end else if (mc_active[k] != 0) begin
         if (mc_done) begin
            mc_active[k] = 0;
         end else begin
            e = V_BUSY;
            mc_age[k]++;
            if (mc_age[k] == tmo[k]) begin
               mc_active[k] = 0;
               to_m[k] = 1;
            end
         end
      end else if (load_left[k] > 0) begin
         e = V_HAZ;
         load_left[k]--;
      end else if (mc_start_exe) begin
         mc_active[k] = 1;
         mc_age[k] = 0;
      end else if (hz) begin
         e = V_HAZ;
         load_left[k] = lat[k] - 1;
      end
      if (!e[8] && stalls_m[k] < 255) stalls_m[k]++;
   endtask

   // Entered just after a falling edge with inputs already driven
   task automatic runCycle();
      logic [8:0] ea, eb;
      #2;
      if (primed) begin
         checkOutput("A.mc_timeout", 32'(to_a), 32'(to_m[0]));
         checkOutput("A.stall_cycles", 32'(sc_a), 32'(stalls_m[0]));
         checkOutput("B.mc_timeout", 32'(to_b), 32'(to_m[1]));
         checkOutput("B.stall_cycles", 32'(sc_b), 32'(stalls_m[1]));
      end
      modelCycle(0, ea);
      modelCycle(1, eb);
      checkOutput("A.ctl", 32'(ctl_a), 32'(ea));
      checkOutput("B.ctl", 32'(ctl_b), 32'(eb));
      if (reset) primed = 1'b1;
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic rst, input logic stl, input logic br,
                                input logic mcs, input logic mcd, input logic hz);
      reset        = rst;
      stall_pipl   = stl;
      branch_taken = br;
      mc_start_exe = mcs;
      mc_done      = mcd;
      mem_read_exe = hz;
      rd_exe       = 5'd5;
      rs1_id       = 5'd5;
      use_rs1_id   = 1'b1;
      rs2_id       = 5'd7;
      use_rs2_id   = 1'b0;
      runCycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      @(negedge clk);
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      idle(2);

      // Load-use: A gives 3 bubbles, B gives 1
      applyStimulus(0, 0, 0, 0, 0, 1);
      idle(4);
      checkOutput("A.ld_bubbles", 32'(sc_a), 32'd3);
      checkOutput("B.ld_bubbles", 32'(sc_b), 32'd1);

      // Load into x0 is never a hazard
      reset = 0; stall_pipl = 0; branch_taken = 0; mc_start_exe = 0; mc_done = 0;
      mem_read_exe = 1; rd_exe = 5'd0; rs1_id = 5'd0; use_rs1_id = 1; rs2_id = 5'd0; use_rs2_id = 1;
      runCycle();
      idle(1);
      checkOutput("A.x0_no_stall", 32'(sc_a), 32'd3);

      // Branch on 2nd then 1st LD_STALL cycle
      applyStimulus(0, 0, 0, 0, 0, 1);
      idle(1);
      applyStimulus(0, 0, 1, 0, 0, 0);
      idle(2);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 1, 0, 0, 0);
      idle(3);

      // Multicycle op done after 10 busy cycles (B times out at 8)
      applyStimulus(0, 0, 0, 1, 0, 0);
      idle(10);
      applyStimulus(0, 0, 0, 0, 1, 0);
      idle(2);
      checkOutput("A.no_timeout", 32'(to_a), 32'd0);
      checkOutput("B.timeout", 32'(to_b), 32'd1);

      // No done at all: A times out after 12
      applyStimulus(0, 0, 0, 1, 0, 0);
      idle(14);
      applyStimulus(0, 0, 0, 0, 1, 0);
      idle(1);
      checkOutput("A.timeout_sticky", 32'(to_a), 32'd1);

      // MC start coincident with load-use, then external stall during MC_BUSY, then reset mid-MC
      applyStimulus(0, 0, 0, 1, 0, 1);
      idle(3);
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0, 0);
      idle(2);
      applyStimulus(1, 0, 0, 0, 0, 0);
      idle(3);
      checkOutput("A.timeout_cleared", 32'(to_a), 32'd0);

      // Saturation of the 8-bit stall counter
      for (int i = 0; i < 260; i++) applyStimulus(0, 1, 0, 0, 0, 0);
      idle(1);
      checkOutput("A.saturated", 32'(sc_a), 32'hFF);

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         reset        = ($urandom_range(0, 99) == 0);
         stall_pipl   = ($urandom_range(0, 9) == 0);
         branch_taken = ($urandom_range(0, 11) == 0);
         mc_start_exe = ($urandom_range(0, 9) == 0);
         mc_done      = ($urandom_range(0, 7) == 0);
         mem_read_exe = 1'($urandom_range(0, 1));
         rd_exe       = 5'($urandom_range(0, 3));
         rs1_id       = 5'($urandom_range(0, 3));
         rs2_id       = 5'($urandom_range(0, 3));
         use_rs1_id   = 1'($urandom_range(0, 1));
         use_rs2_id   = 1'($urandom_range(0, 1));
         runCycle();
      end

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
